product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter PRODW, default 16, giving the width of the unsigned product word consumed from the upstream registered multiplier (bitwidthA+bitwidthB).
REQ-002 SHALL have parameter ACCW, default 24, giving the accumulator and result width; ACCW >= PRODW.
REQ-003 SHALL have parameter TERMS, default 8, giving the number of products summed per result; TERMS >= 2.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: a single-cycle request to begin a new accumulation run.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data holds a valid product.
REQ-008 SHALL have port in_data, input, PRODW bits: the unsigned product term.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts a term this cycle.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds a completed result.
REQ-011 SHALL have port out_data, output, ACCW bits: the accumulated sum.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream consumer takes the result.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port sat, output, 1 bit: sticky flag, set when saturation occurred in the current or last run.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCUM and DONE, with all outputs driven from registers.
REQ-016 In IDLE with start=1, the block SHALL clear the accumulator, term count and sat, and enter ACCUM next cycle.
REQ-017 SHALL ignore start in ACCUM and DONE, with no effect on any state.
REQ-018 In ACCUM, in_ready SHALL be 1; in IDLE and DONE, in_ready SHALL be 0.
REQ-019 A term SHALL transfer only on a cycle with in_valid=1 and in_ready=1; in_valid=0 cycles (bubbles) SHALL leave acc and count unchanged.
REQ-020 On each transfer, acc SHALL become acc + zero-extended in_data, and the count SHALL increment by 1.
REQ-021 If the unsigned sum is >= 2^ACCW, acc SHALL saturate to 2^ACCW-1 and sat SHALL be set to 1; later terms SHALL keep acc at 2^ACCW-1.
REQ-022 On the TERMS-th transfer, the final acc SHALL load into out_data and the FSM SHALL enter DONE; out_valid SHALL be 1 on the cycle after that transfer (1-cycle latency).
REQ-023 In DONE, out_valid=1 and out_data SHALL stay stable until a cycle with out_ready=1; on that cycle the FSM SHALL return to IDLE and out_valid SHALL be 0 the next cycle.
REQ-024 out_ready SHALL be ignored when out_valid=0.
REQ-025 out_data and sat SHALL hold their values in IDLE until the next start.
REQ-026 If start and out_ready are both 1 in DONE, the result handshake SHALL complete, start SHALL be ignored, and the FSM SHALL go to IDLE.

Reset
REQ-027 While reset=0, the FSM SHALL be in IDLE and acc, count, out_data, out_valid, in_ready, busy and sat SHALL all be 0, regardless of clock.
REQ-028 Reset asserted mid-ACCUM or mid-DONE SHALL discard the partial or pending result, with no out_valid pulse after release.
REQ-029 After reset deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-030 Defaults; start, then 8 back-to-back terms of 1..8 -> out_valid 1 cycle after the 8th transfer, out_data=36, sat=0.
REQ-031 Same terms with in_valid low on alternate cycles -> out_data=36; in_ready high throughout ACCUM; count unaffected by bubbles.
REQ-032 8 terms of 0xFFFF with ACCW=24 -> out_data=0x07FFF8, sat=0; rerun with ACCW=18 -> out_data=0x3FFFF, sat=1.
REQ-033 out_ready held low for 5 cycles in DONE -> out_valid and out_data stable for all 5 cycles; start pulsed in DONE is ignored; on out_ready=1, out_valid drops and busy=0 next cycle.
REQ-034 reset driven low after the 3rd term, asynchronous to clock -> outputs 0 immediately; after release, no out_valid; a new start with 8 terms of 2 -> out_data=16.
REQ-035 Back-to-back runs: start in the IDLE cycle right after the handshake -> acc and sat cleared; the second result is independent of the first.

Source files
------------

// File: rtl/product_accumulator.sv
// ============================================================================
// product_accumulator
// ----------------------------------------------------------------------------
// Sums a fixed number of unsigned product words coming from an upstream
// registered multiplier and presents the total as a single result word.
// The sum saturates at the largest value the accumulator can hold. A sticky
// flag records that saturation happened during the run.
//
// A run has three phases:
//   IDLE  : waiting for a single-cycle start pulse. The previous result and
//           the saturation flag stay visible here.
//   ACCUM : in_ready is high and a term is taken on every in_valid cycle.
//           Bubbles (in_valid low) are allowed. After TERMS transfers the
//           result is registered.
//   DONE  : out_valid is high and out_data is held until out_ready.
//
// Every output is taken straight from a flop. The next-state logic therefore
// computes the next value of each output together with the next FSM state.
//
// Parameters
//   PRODW : width of the incoming unsigned product word
//   ACCW  : accumulator / result width (ACCW >= PRODW)
//   TERMS : number of products summed per result (TERMS >= 2)
//
// Ports
//   clock     : in  - single clock, rising-edge active
//   reset     : in  - asynchronous, active-low reset
//   start     : in  - single-cycle request to begin a run (used only in IDLE)
//   in_valid  : in  - in_data carries a valid product
//   in_data   : in  - unsigned product term, PRODW bits
//   in_ready  : out - a term is accepted this cycle (high only in ACCUM)
//   out_valid : out - out_data carries a completed result (high in DONE)
//   out_data  : out - accumulated, saturated sum, ACCW bits
//   out_ready : in  - downstream takes the result (used only in DONE)
//   busy      : out - high in every state except IDLE
//   sat       : out - sticky: saturation occurred in the current/last run
// ============================================================================
module product_accumulator #(
    parameter int PRODW = 16,
    parameter int ACCW  = 24,
    parameter int TERMS = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [PRODW-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [ACCW-1:0]  out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             sat
);

    // The counter must be able to hold TERMS itself, because it increments
    // on the final transfer as well.
    localparam int              CNTW = $clog2(TERMS + 1);
    localparam logic [CNTW-1:0] LAST = CNTW'(TERMS - 1);
    localparam logic [CNTW-1:0] ONE  = CNTW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ACCW-1:0]   acc;
    logic [ACCW-1:0]   acc_next;
    logic [CNTW-1:0]   count;
    logic [CNTW-1:0]   count_next;
    logic [ACCW-1:0]   out_data_next;
    logic              out_valid_next;
    logic              in_ready_next;
    logic              busy_next;
    logic              sat_next;

    logic [ACCW:0]     sum_wide;
    logic [ACCW-1:0]   sum_sat;
    logic              overflow;
    logic              transfer;

    // Saturating adder. The sum is formed one bit wider than the
    // accumulator so that the carry out flags an overflow directly. The
    // product is zero-extended to the same width. On a carry the result
    // clamps to all ones. An already-saturated accumulator therefore stays
    // at the maximum for every later term.
    always_comb begin
        sum_wide = {1'b0, acc} + {{(ACCW - PRODW + 1){1'b0}}, in_data};
        overflow = sum_wide[ACCW];
        sum_sat  = overflow ? {ACCW{1'b1}} : sum_wide[ACCW-1:0];
        transfer = in_valid && in_ready;
    end

    // Next-state and next-output logic. Every register holds its value by
    // default, and each state changes only what it owns. start is looked at
    // only in IDLE and out_ready only in DONE. Both are therefore ignored
    // everywhere else without any extra gating. When start and out_ready are
    // both high in DONE, the DONE branch completes the handshake and the
    // start pulse is dropped.
    always_comb begin
        state_next     = state;
        acc_next       = acc;
        count_next     = count;
        out_data_next  = out_data;
        out_valid_next = out_valid;
        in_ready_next  = in_ready;
        busy_next      = busy;
        sat_next       = sat;

        case (state)
            IDLE: begin
                if (start) begin
                    acc_next      = '0;
                    count_next    = '0;
                    sat_next      = 1'b0;
                    in_ready_next = 1'b1;
                    busy_next     = 1'b1;
                    state_next    = ACCUM;
                end
            end

            ACCUM: begin
                if (transfer) begin
                    acc_next   = sum_sat;
                    count_next = count + ONE;
                    if (overflow) begin
                        sat_next = 1'b1;
                    end
                    // The last term goes straight into the result register.
                    // out_valid then rises on the very next cycle.
                    if (count == LAST) begin
                        out_data_next  = sum_sat;
                        out_valid_next = 1'b1;
                        in_ready_next  = 1'b0;
                        state_next     = DONE;
                    end
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    busy_next      = 1'b0;
                    state_next     = IDLE;
                end
            end

            default: begin
                in_ready_next  = 1'b0;
                out_valid_next = 1'b0;
                busy_next      = 1'b0;
                state_next     = IDLE;
            end
        endcase
    end

    // State and output registers. Reset clears everything at once, without
    // waiting for a clock edge. This drops any partial or pending result,
    // so no out_valid can appear after reset is released.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            sat       <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            count     <= count_next;
            out_data  <= out_data_next;
            out_valid <= out_valid_next;
            in_ready  <= in_ready_next;
            busy      <= busy_next;
            sat       <= sat_next;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// ============================================================================
// tb_product_accumulator
// ----------------------------------------------------------------------------
// Drives two product_accumulator instances with the same stimulus:
//   - the default 24-bit accumulator
//   - an 18-bit accumulator, so that saturation is reachable with 16-bit
//     products
// The expected result of each run is computed from the terms themselves:
// the plain arithmetic sum, clamped at 2^ACCW-1. The saturation flag is
// expected whenever the true sum exceeds that limit.
// ============================================================================
module tb_product_accumulator;

    logic        clock;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_busy, a_sat;
    logic [23:0] a_out_data;
    logic        b_in_ready, b_out_valid, b_busy, b_sat;
    logic [17:0] b_out_data;

    int          nChecks;
    int          nFails;
    logic [15:0] terms [0:7];

    product_accumulator #(.PRODW(16), .ACCW(24), .TERMS(8)) dutA (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_ready (out_ready),
        .busy      (a_busy),
        .sat       (a_sat)
    );

    product_accumulator #(.PRODW(16), .ACCW(18), .TERMS(8)) dutB (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_ready (out_ready),
        .busy      (b_busy),
        .sat       (b_sat)
    );

    // 10-unit clock period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: the true sum of the current terms, clamped to the
    // accumulator width.
    function automatic longint unsigned trueSum();
        longint unsigned s = 0;
        for (int i = 0; i < 8; i++) s += longint'(terms[i]);
        return s;
    endfunction

    function automatic longint unsigned expData(input int w);
        longint unsigned lim = (longint'(1) << w) - 1;
        return (trueSum() > lim) ? lim : trueSum();
    endfunction

    function automatic logic expSat(input int w);
        return trueSum() > ((longint'(1) << w) - 1);
    endfunction

    // One comparison: counted, and reported on mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle. Inputs are driven and outputs sampled 1 unit after
    // the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic startRun(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput({tag, ".busyA"},    64'(a_busy),     64'd1);
        checkOutput({tag, ".readyA"},   64'(a_in_ready), 64'd1);
        checkOutput({tag, ".readyB"},   64'(b_in_ready), 64'd1);
        checkOutput({tag, ".satClrA"},  64'(a_sat),      64'd0);
        checkOutput({tag, ".satClrB"},  64'(b_sat),      64'd0);
        checkOutput({tag, ".noValidA"}, 64'(a_out_valid), 64'd0);
    endtask

    // Feeds the 8 terms, with optional bubble cycles. Checks that in_ready
    // stays high through ACCUM and that out_valid rises exactly one cycle
    // after the 8th transfer.
    task automatic applyStimulus(input string tag, input int bubbleMode);
        for (int i = 0; i < 8; i++) begin
            if (bubbleMode == 1 || (bubbleMode == 2 && $urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                tick();
                checkOutput({tag, ".bubbleReady"}, 64'(a_in_ready), 64'd1);
                checkOutput({tag, ".bubbleNoValid"}, 64'(a_out_valid), 64'd0);
            end
            checkOutput({tag, ".ready"}, 64'(a_in_ready & b_in_ready), 64'd1);
            in_valid = 1'b1;
            in_data  = terms[i];
            tick();
            in_valid = 1'b0;
            in_data  = 16'($urandom);
            checkOutput({tag, ".validA"}, 64'(a_out_valid), (i == 7) ? 64'd1 : 64'd0);
            checkOutput({tag, ".validB"}, 64'(b_out_valid), (i == 7) ? 64'd1 : 64'd0);
        end
    endtask

    task automatic checkResult(input string tag);
        checkOutput({tag, ".dataA"},  64'(a_out_data), expData(24));
        checkOutput({tag, ".dataB"},  64'(b_out_data), expData(18));
        checkOutput({tag, ".satA"},   64'(a_sat),      64'(expSat(24)));
        checkOutput({tag, ".satB"},   64'(b_sat),      64'(expSat(18)));
        checkOutput({tag, ".doneReady"}, 64'(a_in_ready), 64'd0);
        checkOutput({tag, ".doneBusy"},  64'(a_busy),     64'd1);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, ".hsValidA"}, 64'(a_out_valid), 64'd0);
        checkOutput({tag, ".hsValidB"}, 64'(b_out_valid), 64'd0);
        checkOutput({tag, ".hsBusyA"},  64'(a_busy),      64'd0);
        checkOutput({tag, ".hsBusyB"},  64'(b_busy),      64'd0);
        checkOutput({tag, ".hsHoldA"},  64'(a_out_data),  expData(24));
        checkOutput({tag, ".hsSatB"},   64'(b_sat),       64'(expSat(18)));
    endtask

    initial begin
        nChecks   = 0;
        nFails    = 0;
        reset     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state, checked before any clock edge and after several
        // edges. start is high during reset and must have no effect.
        #2;
        checkOutput("rst.pre.busy", 64'(a_busy), 64'd0);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        checkOutput("rst.validA", 64'(a_out_valid), 64'd0);
        checkOutput("rst.readyA", 64'(a_in_ready),  64'd0);
        checkOutput("rst.busyA",  64'(a_busy),      64'd0);
        checkOutput("rst.satA",   64'(a_sat),       64'd0);
        checkOutput("rst.dataA",  64'(a_out_data),  64'd0);
        checkOutput("rst.dataB",  64'(b_out_data),  64'd0);
        reset = 1'b1;
        tick();
        tick();
        checkOutput("idle.wait.busy", 64'(a_busy), 64'd0);

        // Terms 1..8 back to back -> 36.
        for (int i = 0; i < 8; i++) terms[i] = 16'(i + 1);
        startRun("seq");
        applyStimulus("seq", 0);
        checkResult("seq");
        handshake("seq");

        // Same terms with a bubble before every term -> still 36.
        startRun("bub");
        applyStimulus("bub", 1);
        checkResult("bub");
        handshake("bub");

        // All 0xFFFF: 0x07FFF8 in 24 bits, saturated 0x3FFFF in 18 bits.
        for (int i = 0; i < 8; i++) terms[i] = 16'hFFFF;
        startRun("ffff");
        applyStimulus("ffff", 0);
        checkResult("ffff");
        checkOutput("ffff.constA", 64'(a_out_data), 64'h07FFF8);
        checkOutput("ffff.constB", 64'(b_out_data), 64'h3FFFF);

        // Hold DONE for 5 cycles with a start pulse in the middle.
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            tick();
            start = 1'b0;
            checkOutput("hold.validA", 64'(a_out_valid), 64'd1);
            checkOutput("hold.dataA",  64'(a_out_data),  64'h07FFF8);
            checkOutput("hold.dataB",  64'(b_out_data),  64'h3FFFF);
            checkOutput("hold.busyA",  64'(a_busy),      64'd1);
        end

        // start together with out_ready: the handshake wins.
        start = 1'b1;
        handshake("hsStart");
        start = 1'b0;
        checkOutput("hsStart.readyA", 64'(a_in_ready), 64'd0);
        tick();
        checkOutput("idle.satHoldB", 64'(b_sat),      64'd1);
        checkOutput("idle.dataHold", 64'(b_out_data), 64'h3FFFF);
        checkOutput("idle.stay",     64'(a_busy),     64'd0);

        // Back-to-back runs with random terms and random bubbles. Each start
        // arrives in the first IDLE cycle after the handshake.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++)
                terms[i] = 16'($urandom_range(0, (r % 2 == 0) ? 32'h3FFF : 32'hFFFF));
            startRun("rnd");
            applyStimulus("rnd", 2);
            checkResult("rnd");
            handshake("rnd");
        end

        // Asynchronous reset after the 3rd term, in the middle of a cycle.
        for (int i = 0; i < 8; i++) terms[i] = 16'd100;
        startRun("arst");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = terms[i];
            tick();
        end
        in_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        checkOutput("arst.readyA", 64'(a_in_ready),  64'd0);
        checkOutput("arst.busyA",  64'(a_busy),      64'd0);
        checkOutput("arst.busyB",  64'(b_busy),      64'd0);
        checkOutput("arst.validA", 64'(a_out_valid), 64'd0);
        checkOutput("arst.dataA",  64'(a_out_data),  64'd0);
        checkOutput("arst.satA",   64'(a_sat),       64'd0);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            tick();
            checkOutput("arst.noValid", 64'(a_out_valid | b_out_valid), 64'd0);
            checkOutput("arst.idle",    64'(a_busy | b_busy),           64'd0);
        end
        in_valid = 1'b0;

        // Fresh run of 8 terms of 2 -> 16.
        for (int i = 0; i < 8; i++) terms[i] = 16'd2;
        startRun("post");
        applyStimulus("post", 0);
        checkResult("post");
        checkOutput("post.const", 64'(a_out_data), 64'd16);
        handshake("post");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
